// File: rtl/floppy_pkg.sv
// Shared types for the floppy sector reader: FSM states, status codes and
// the size-code to byte-count mapping.
package floppy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEEK      = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_CAPTURE   = 2'd3
  } state_e;

  localparam logic [1:0] STAT_OK      = 2'd0;
  localparam logic [1:0] STAT_CRC     = 2'd1;
  localparam logic [1:0] STAT_TIMEOUT = 2'd2;
  localparam logic [1:0] STAT_OVF     = 2'd3;

  // Sector payload length: 128 << code (code 7 still fits in 16 bits).
  function automatic logic [15:0] size_bytes(input logic [2:0] code);
    return 16'd128 << code;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO of 9-bit entries {last, data}; outputs zero
// while empty. A push into a full FIFO is accepted only with a same-cycle pop.
module byte_fifo #(
  parameter int DEPTH = 512
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Push,
  input  logic [8:0] i_Din,
  input  logic       i_Pop,
  output logic [8:0] o_Dout,
  output logic       o_Full,
  output logic       o_Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic [8:0]    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign o_Full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_Empty = (cnt_q == '0);
  assign do_pop  = i_Pop & ~o_Empty;
  assign do_push = i_Push & (~o_Full | do_pop);
  assign o_Dout  = o_Empty ? 9'd0 : mem_q[rd_q];

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (do_push) mem_q[wr_q] <= i_Din;
  end

endmodule

// File: rtl/sector_reader.sv
// Floppy sector reader: finds the requested sector header, captures its data
// field into a FWFT byte FIFO and reports completion status.
// Define FLOPPY_READ_TIMEOUT_EN to abort after TIMEOUT_REVS index pulses.
module sector_reader
  import floppy_pkg::*;
#(
  parameter int DEPTH         = 512,
  parameter int MAX_SIZE_CODE = 2,
  parameter int TIMEOUT_REVS  = 5
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Index,
  input  logic       i_HeaderValid,
  input  logic [7:0] i_Track,
  input  logic [7:0] i_Side,
  input  logic [7:0] i_Sector,
  input  logic [7:0] i_SectorSize,
  input  logic       i_HeaderCRCError,
  input  logic [7:0] i_SecData,
  input  logic       i_SecValid,
  input  logic       i_DataDone,
  input  logic       i_DataCRCError,
  input  logic       i_ReqValid,
  output logic       o_ReqReady,
  input  logic [7:0] i_ReqTrack,
  input  logic [7:0] i_ReqSide,
  input  logic [7:0] i_ReqSector,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  input  logic       i_Ready,
  output logic       o_Last,
  output logic       o_Done,
  output logic [1:0] o_Status
);

  state_e      state_q, state_d;
  logic [7:0]  trk_q, trk_d, side_q, side_d, sec_q, sec_d;
  logic [2:0]  size_q, size_d, size_clamp;
  logic [15:0] cnt_q, cnt_d, n_bytes;
  logic        ovf_q, ovf_d, done_q, done_d;
  logic [1:0]  stat_q, stat_d;
  logic        push, push_last, pop, drop, full, empty, hdr_match, tmo_hit;
  logic [8:0]  fifo_dout;

  assign n_bytes    = size_bytes(size_q);
  assign size_clamp = (i_SectorSize > 8'(MAX_SIZE_CODE)) ? 3'(MAX_SIZE_CODE) : i_SectorSize[2:0];
  assign hdr_match  = i_HeaderValid & ~i_HeaderCRCError &
                      (i_Track == trk_q) & (i_Side == side_q) & (i_Sector == sec_q);

  // cnt_q is zero in WAIT_DATA, so the same tag test covers the first byte.
  assign push      = i_SecValid & ((state_q == ST_WAIT_DATA) |
                                   ((state_q == ST_CAPTURE) & (cnt_q < n_bytes)));
  assign push_last = (cnt_q == n_bytes - 16'd1);
  assign pop       = o_Valid & i_Ready;
  assign drop      = push & full & ~pop;

`ifdef FLOPPY_READ_TIMEOUT_EN
  localparam int REV_W = $clog2(TIMEOUT_REVS + 1);
  logic             idx_q, idx_edge, waiting;
  logic [REV_W-1:0] rev_q, rev_d;

  assign idx_edge = i_Index & ~idx_q;
  assign waiting  = (state_q == ST_SEEK) | (state_q == ST_WAIT_DATA);
  assign tmo_hit  = waiting & idx_edge & (rev_q == REV_W'(TIMEOUT_REVS - 1));

  always_comb begin
    rev_d = rev_q;
    if (state_q == ST_IDLE && i_ReqValid) rev_d = '0;
    else if (waiting && idx_edge)         rev_d = rev_q + 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      idx_q <= 1'b0;
      rev_q <= '0;
    end else begin
      idx_q <= i_Index;
      rev_q <= rev_d;
    end
  end
`else
  logic unused_idx;
  assign unused_idx = i_Index ^ (TIMEOUT_REVS == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    trk_d   = trk_q;
    side_d  = side_q;
    sec_d   = sec_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | drop;
    done_d  = 1'b0;
    stat_d  = stat_q;
    case (state_q)
      ST_IDLE: if (i_ReqValid) begin
        trk_d   = i_ReqTrack;
        side_d  = i_ReqSide;
        sec_d   = i_ReqSector;
        ovf_d   = 1'b0;
        state_d = ST_SEEK;
      end
      ST_SEEK: if (hdr_match) begin
        size_d  = size_clamp;
        cnt_d   = '0;
        state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (i_SecValid) begin
          cnt_d   = 16'd1;
          state_d = ST_CAPTURE;
        end else if (i_HeaderValid) begin
          state_d = ST_SEEK;
        end
      end
      ST_CAPTURE: begin
        if (push) cnt_d = cnt_q + 16'd1;
        if (i_DataDone) begin
          done_d  = 1'b1;
          stat_d  = (ovf_q | drop) ? STAT_OVF : (i_DataCRCError ? STAT_CRC : STAT_OK);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_hit) begin
      done_d  = 1'b1;
      stat_d  = STAT_TIMEOUT;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q <= ST_IDLE;
      trk_q   <= '0;
      side_q  <= '0;
      sec_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      stat_q  <= STAT_OK;
    end else begin
      state_q <= state_d;
      trk_q   <= trk_d;
      side_q  <= side_d;
      sec_q   <= sec_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      stat_q  <= stat_d;
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .i_Push    (push),
    .i_Din     ({push_last, i_SecData}),
    .i_Pop     (pop),
    .o_Dout    (fifo_dout),
    .o_Full    (full),
    .o_Empty   (empty)
  );

  assign o_Valid    = ~empty;
  assign o_Data     = fifo_dout[7:0];
  assign o_Last     = fifo_dout[8];
  assign o_Done     = done_q;
  assign o_Status   = stat_q;
  assign o_ReqReady = (state_q == ST_IDLE);

endmodule

// File: doc/sector_reader.md
SECTOR_READER -- requirements
Module: sector_reader

Interface
REQ-001 Parameters SHALL be: DEPTH, default 512, FIFO entries (power of 2, >=4); MAX_SIZE_CODE, default 2, largest accepted size code (bytes = 128<<code); TIMEOUT_REVS, default 5, index pulses before abort.
REQ-002 Ports SHALL be: i_Clk in 1 system clock; i_Reset_n in 1 synchronous active-low reset; i_Index in 1 drive index pulse.
REQ-003 Ports SHALL be: i_HeaderValid in 1; i_Track, i_Side, i_Sector, i_SectorSize in 8 each; i_HeaderCRCError in 1. These are header fields qualified by i_HeaderValid.
REQ-004 Ports SHALL be: i_SecData in 8; i_SecValid in 1 (data byte strobe); i_DataDone in 1 (end-of-field pulse); i_DataCRCError in 1, qualified by i_DataDone.
REQ-005 Ports SHALL be: i_ReqValid in 1; o_ReqReady out 1; i_ReqTrack, i_ReqSide, i_ReqSector in 8 each.
REQ-006 Ports SHALL be: o_Data out 8; o_Valid out 1; i_Ready in 1; o_Last out 1; o_Done out 1; o_Status out 2 (0 OK, 1 data CRC, 2 timeout, 3 overflow).

Function
REQ-007 FSM SHALL have the states IDLE, SEEK, WAIT_DATA and CAPTURE; o_ReqReady=1 only in IDLE.
REQ-008 On i_ReqValid&&o_ReqReady, the block SHALL latch the track/side/sector and go to SEEK.
REQ-009 In SEEK, i_HeaderValid with all three fields equal and i_HeaderCRCError=0 SHALL latch the size code (clamped to MAX_SIZE_CODE) and go to WAIT_DATA; non-matching or CRC-failed headers SHALL be ignored.
REQ-010 In WAIT_DATA, the first i_SecValid SHALL go to CAPTURE and push that byte; an i_HeaderValid arriving first SHALL return to SEEK.
REQ-011 In CAPTURE, the block SHALL push bytes until N=128<<size have been pushed; later bytes (CRC) SHALL be dropped; the entry of byte N-1 SHALL be tagged last.
REQ-012 i_DataDone in CAPTURE SHALL pulse o_Done for 1 cycle, set o_Status, and go to IDLE; o_Status SHALL hold until the next o_Done.
REQ-013 Status priority SHALL be overflow > data CRC > OK.
REQ-014 A push while full without a same-cycle pop SHALL drop the byte and set a sticky overflow flag, cleared on the next request accept.
REQ-015 Simultaneous push and pop SHALL always succeed, including at full and at empty.
REQ-016 The FIFO output SHALL be first-word-fall-through: o_Valid = not empty, pop on o_Valid&&i_Ready, o_Last = tag of the head entry; pointers SHALL wrap modulo DEPTH.
REQ-017 Output draining SHALL be independent of the FSM and SHALL continue after o_Done.
REQ-018 Latency from i_SecValid to o_Valid (FIFO empty) SHALL be 1 cycle.

Reset
REQ-019 On i_Reset_n=0 at a clock edge, the block SHALL go to IDLE and flush the FIFO, with outputs o_Valid=0, o_Last=0, o_Done=0, o_Status=0, o_Data=0, o_ReqReady=1 (from the cycle after release), and counters and the overflow flag cleared.
REQ-020 A reset asserted mid-capture SHALL abort without o_Done.

Configuration
REQ-021 With FLOPPY_READ_TIMEOUT_EN defined, in SEEK/WAIT_DATA the block SHALL count i_Index rising edges (registered edge detect); on reaching TIMEOUT_REVS it SHALL pulse o_Done with status 2 and go to IDLE; the count SHALL clear on request accept.
REQ-022 Without the macro, i_Index SHALL be ignored and the block SHALL wait indefinitely; status 2 SHALL never be produced.

Structure
REQ-023 Package floppy_pkg SHALL hold the state enum, the status encoding constants, and the size-code-to-byte-count function.
REQ-024 The FIFO SHALL be sub-module byte_fifo: 9-bit width (data+last), parameter DEPTH, with full/empty flags.

Verification
REQ-025 Request T=3,S=0,R=5; headers R=4 then R=5 (size 2), 514 data bytes, DataDone with CRC=0, i_Ready=1 -> exactly 512 bytes out, o_Last on byte 512, o_Done with status 0.
REQ-026 Matching header with HeaderCRCError=1, then a good one -> first header ignored; capture follows the second.
REQ-027 DEPTH=4, size 0, i_Ready=0 -> 4 bytes stored, rest dropped, status 3; draining yields the first 4 bytes.
REQ-028 Valid data field with DataCRCError=1 -> all bytes delivered, status 1.
REQ-029 With the macro, TIMEOUT_REVS=5 and no match -> o_Done with status 2 on the 5th index edge; without the macro -> no o_Done.
REQ-030 i_Reset_n low after 100 bytes captured -> FIFO empty, IDLE, o_ReqReady=1, no o_Done.
